// File: rtl/branch_exec_unit.sv
// rtl/branch_exec_unit.sv - branch resolve pipeline (accept, compute) with in-order CDB result buffer
// Types shared with the issue queue, ROB and testbench live in the package below.

package branch_exec_pkg;
  typedef enum logic [1:0] {
    BR_BR   = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2
  } br_type_e;

  typedef struct packed {
    logic        valid;
    logic [5:0]  ps1;
    logic [5:0]  ps2;
    logic [5:0]  pd;
    logic [4:0]  rob_id;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  funct3;
    br_type_e    br_type;
  } rename_data_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  pd;
    logic [31:0] value;
    logic [4:0]  rob_id;
  } cdb_entry_t;
endpackage

module branch_exec_unit
  import branch_exec_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  rename_data_t branch_entry_in,
  output logic         unit_busy,
  output logic [5:0]   prf_rs1_addr,
  output logic [5:0]   prf_rs2_addr,
  input  logic [31:0]  prf_rs1_data,
  input  logic [31:0]  prf_rs2_data,
  output logic         cdb_req,
  input  logic         cdb_gnt,
  output cdb_entry_t   cdb_out,
  output logic         br_taken,
  output logic [31:0]  br_target,
  output logic         br_mispredict,
  output logic         overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    cdb_entry_t  cdb;
    logic        taken;
    logic [31:0] target;
    logic        mispredict;
  } result_t;

  logic             r_s1_v;
  logic [5:0]       r_s1_pd;
  logic [4:0]       r_s1_rob_id;
  logic [31:0]      r_s1_pc;
  logic [31:0]      r_s1_imm;
  logic [2:0]       r_s1_funct3;
  br_type_e         r_s1_type;

  logic             r_s2_v;
  logic [5:0]       r_s2_pd;
  logic [4:0]       r_s2_rob_id;
  logic [31:0]      r_s2_pc;
  logic [31:0]      r_s2_imm;
  logic [2:0]       r_s2_funct3;
  br_type_e         r_s2_type;
  logic [31:0]      r_s2_rs1;
  logic [31:0]      r_s2_rs2;

  result_t          r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic [CNT_W:0]   w_occupancy;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_pc4;
  logic             w_taken;
  logic [31:0]      w_target;
  result_t          w_result;
  result_t          w_head;

  // Pre-pop occupancy: a grant in this cycle does not free a slot for admission.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_v} + {{CNT_W{1'b0}}, r_s2_v};
  assign unit_busy   = w_occupancy >= (CNT_W + 1)'(FIFO_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_accept    = branch_entry_in.valid && !unit_busy;
  assign w_push      = r_s2_v;
  assign w_pop       = !w_empty && cdb_gnt;

  assign prf_rs1_addr = rst ? branch_entry_in.ps1 : 6'd0;
  assign prf_rs2_addr = rst ? branch_entry_in.ps2 : 6'd0;
  assign overflow_err = r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (branch_entry_in.valid && unit_busy) begin
        r_overflow <= 1'b1;
      end
      if (flush) begin
        r_s1_v   <= 1'b0;
        r_s2_v   <= 1'b0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_s1_v <= w_accept;
        r_s2_v <= r_s1_v;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload registers are qualified by the valid bits above and need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_pd     <= branch_entry_in.pd;
      r_s1_rob_id <= branch_entry_in.rob_id;
      r_s1_pc     <= branch_entry_in.pc;
      r_s1_imm    <= branch_entry_in.imm;
      r_s1_funct3 <= branch_entry_in.funct3;
      r_s1_type   <= branch_entry_in.br_type;
    end
    if (r_s1_v) begin
      r_s2_pd     <= r_s1_pd;
      r_s2_rob_id <= r_s1_rob_id;
      r_s2_pc     <= r_s1_pc;
      r_s2_imm    <= r_s1_imm;
      r_s2_funct3 <= r_s1_funct3;
      r_s2_type   <= r_s1_type;
      r_s2_rs1    <= prf_rs1_data;
      r_s2_rs2    <= prf_rs2_data;
    end
    if (w_push && !flush) begin
      r_fifo[r_wr_ptr] <= w_result;
    end
  end

  assign w_pc4 = r_s2_pc + 32'd4;

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc4;
    w_result = '0;
    case (r_s2_type)
      BR_JAL: begin
        w_taken  = 1'b1;
        w_target = r_s2_pc + r_s2_imm;
      end
      BR_JALR: begin
        w_taken  = 1'b1;
        w_target = (r_s2_rs1 + r_s2_imm) & ~32'h1;
      end
      default: begin
        case (r_s2_funct3)
          3'b000:  w_taken = (r_s2_rs1 == r_s2_rs2);
          3'b001:  w_taken = (r_s2_rs1 != r_s2_rs2);
          3'b100:  w_taken = ($signed(r_s2_rs1) <  $signed(r_s2_rs2));
          3'b101:  w_taken = ($signed(r_s2_rs1) >= $signed(r_s2_rs2));
          3'b110:  w_taken = (r_s2_rs1 <  r_s2_rs2);
          3'b111:  w_taken = (r_s2_rs1 >= r_s2_rs2);
          default: w_taken = 1'b0;
        endcase
        if (w_taken) w_target = r_s2_pc + r_s2_imm;
      end
    endcase
    w_result.cdb.valid  = 1'b1;
    w_result.cdb.rob_id = r_s2_rob_id;
    // Conditional branches have no destination: pd=0 suppresses the register write.
    if (r_s2_type != BR_BR) begin
      w_result.cdb.value = w_pc4;
      w_result.cdb.pd    = r_s2_pd;
    end
    w_result.taken      = w_taken;
    w_result.target     = w_target;
    w_result.mispredict = (w_target != w_pc4);
  end

  always_comb begin
    w_head        = r_fifo[r_rd_ptr];
    cdb_req       = !w_empty;
    cdb_out       = '0;
    br_taken      = 1'b0;
    br_target     = 32'd0;
    br_mispredict = 1'b0;
    if (!w_empty) begin
      cdb_out       = w_head.cdb;
      br_taken      = w_head.taken;
      br_target     = w_head.target;
      br_mispredict = w_head.mispredict;
    end
  end

endmodule
